// File: rtl/vid_timing_gen.sv
// Raster timing generator: hs/vs/de, active x/y, start-of-frame and busy, all registered.
// Define VID_TIMING_GEN_PATTERN_EN to add an 8-bar colour pattern on rgb_o (otherwise rgb_o is 0).
module vid_timing_gen #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        en_i,
  output logic        hs_o,
  output logic        vs_o,
  output logic        de_o,
  output logic [11:0] x_o,
  output logic [11:0] y_o,
  output logic        sof_o,
  output logic [23:0] rgb_o,
  output logic        busy_o
);

  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_S = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_E = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_S = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_E = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [11:0] h_cnt, v_cnt;
  logic        frame_end, active, de_now, hs_now, vs_now;

  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign active    = (state != IDLE);
  assign de_now    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_now    = (h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E);
  assign vs_now    = (v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // en_i only matters at the frame's last clock once running; a RUN frame ending with
  // en_i low goes straight to IDLE rather than starting another frame in DRAIN.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (en_i) state_nxt = RUN;
      RUN: begin
        if (!en_i) state_nxt = frame_end ? IDLE : DRAIN;
      end
      DRAIN:   if (frame_end) state_nxt = en_i ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || !active) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // Outputs show the counter state of the previous cycle; idle drives the inactive levels.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || !active) begin
      hs_o  <= ~HS_POL;
      vs_o  <= ~VS_POL;
      de_o  <= 1'b0;
      x_o   <= '0;
      y_o   <= '0;
      sof_o <= 1'b0;
    end else begin
      hs_o  <= hs_now ? HS_POL : ~HS_POL;
      vs_o  <= vs_now ? VS_POL : ~VS_POL;
      de_o  <= de_now;
      x_o   <= de_now ? h_cnt : '0;
      y_o   <= de_now ? v_cnt : '0;
      sof_o <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) busy_o <= 1'b0;
    else         busy_o <= active;
  end

`ifdef VID_TIMING_GEN_PATTERN_EN
  logic [2:0] bar;

  // Bar colours follow the binary index: R = ~bar[1], G = ~bar[2], B = ~bar[0].
  always_comb begin
    bar = 3'((32'(h_cnt) * 8) / H_ACTIVE);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || !active || !de_now) rgb_o <= '0;
    else rgb_o <= {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
  end
`else
  assign rgb_o = '0;
`endif

endmodule

// File: tb/tb_vid_timing_gen.sv
// Randomised bench for vid_timing_gen against a frame-position reference model,
// plus frame-level checks (sof spacing, de and vsync counts per frame, reset-to-sof latency).
module tb_vid_timing_gen;

  localparam int HA = 8, HFP = 2, HSY = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam logic HSP = 1'b1, VSP = 1'b0;

  logic        clk_i = 1'b0;
  logic        rstn_i, en_i;
  logic        hs_o, vs_o, de_o, sof_o, busy_o;
  logic [11:0] x_o, y_o;
  logic [23:0] rgb_o;

  vid_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .en_i(en_i),
    .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .x_o(x_o), .y_o(y_o),
    .sof_o(sof_o), .rgb_o(rgb_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Reference model: a running flag plus a linear position inside the frame.
  bit          m_run = 1'b0;
  int          m_pos = 0;
  logic        e_hs, e_vs, e_de, e_sof, e_busy;
  logic [11:0] e_x, e_y;
  logic [23:0] e_rgb;

  task automatic model_step(input logic rst_n, input logic en);
    int h, v;
    e_hs = ~HSP; e_vs = ~VSP; e_de = 1'b0; e_sof = 1'b0; e_busy = 1'b0;
    e_x = '0; e_y = '0; e_rgb = '0;
    if (!rst_n) begin
      m_run = 1'b0;
      m_pos = 0;
    end else if (!m_run) begin
      if (en) m_run = 1'b1;
    end else begin
      h = m_pos % HT;
      v = m_pos / HT;
      e_busy = 1'b1;
      e_de   = (h < HA) && (v < VA);
      e_hs   = (h >= HA + HFP && h < HA + HFP + HSY) ? HSP : ~HSP;
      e_vs   = (v >= VA + VFP && v < VA + VFP + VSY) ? VSP : ~VSP;
      e_sof  = (m_pos == 0);
      if (e_de) begin
        e_x = 12'(h);
        e_y = 12'(v);
`ifdef VID_TIMING_GEN_PATTERN_EN
        e_rgb = BARS[(h * 8) / HA];
`endif
      end
      if (m_pos == FRAME - 1) begin
        m_pos = 0;
        m_run = en;
      end else begin
        m_pos++;
      end
    end
  endtask

  // Frame-level tracker on observed outputs.
  int last_sof = -1;
  int de_cnt = 0;
  int vs_cnt = 0;

  task automatic tick();
    @(posedge clk_i);
    cyc++;
    model_step(rstn_i, en_i);
    #1;
    check("hs", hs_o, e_hs);
    check("vs", vs_o, e_vs);
    check("de", de_o, e_de);
    check("x", x_o, e_x);
    check("y", y_o, e_y);
    check("sof", sof_o, e_sof);
    check("busy", busy_o, e_busy);
    check("rgb", rgb_o, e_rgb);
    if (!busy_o) begin
      last_sof = -1;
      de_cnt = 0;
      vs_cnt = 0;
    end else begin
      if (sof_o) begin
        if (last_sof >= 0) begin
          check("sof_gap", cyc - last_sof, FRAME);
          check("de_per_frame", de_cnt, HA * VA);
          check("vs_per_frame", vs_cnt, HT * VSY);
        end
        last_sof = cyc;
        de_cnt = 0;
        vs_cnt = 0;
      end
      if (de_o) de_cnt++;
      if (vs_o == VSP) vs_cnt++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to_pos(input int pos);
    int budget = 4 * FRAME;
    while (!(m_run && m_pos == pos) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("timeout_pos", 32'(m_pos), 32'(pos));
  endtask

  initial begin
    int sof_lat;
    rstn_i = 1'b0;
    en_i   = 1'b0;
    run(3);

    // Continuous frames from reset.
    rstn_i = 1'b1;
    en_i   = 1'b1;
    run(3 * FRAME + 10);

    // Drop en_i during line 1: frame completes, then idle.
    run_to_pos(HT + 2);
    en_i = 1'b0;
    run(2 * FRAME);
    check("idle_after_drain", busy_o, 1'b0);

    // Re-enable inside DRAIN: no gap between frames.
    en_i = 1'b1;
    run_to_pos(20);
    en_i = 1'b0;
    run(30);
    en_i = 1'b1;
    run(2 * FRAME + 5);

    // Reset mid-frame on line 2 with en_i held.
    run_to_pos(2 * HT + 3);
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    sof_lat = 0;
    for (int i = 1; i <= 6 && sof_lat == 0; i++) begin
      tick();
      if (sof_o) sof_lat = i;
    end
    check("sof_after_reset", sof_lat, 2);
    run(FRAME + 4);

    // Random en_i toggling with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) en_i = ~en_i;
      rstn_i = ($urandom_range(0, 799) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
